// File: rtl/pls_acq_ctrl_if.sv
// Host/counter/FIFO signal bundle for the acquisition sequencer.
// The slave modport is the sequencer's view; master is the driving environment.
interface pls_acq_ctrl_if;
    logic        cmd_start;
    logic        cmd_stop;
    logic [31:0] cfg_tau;
    logic [31:0] cfg_nbins;
    logic        cnt_reset;
    logic        cnt_write;
    logic [31:0] cnt_tau;
    logic        cnt_rdy;
    logic [63:0] cnt_data;
    logic        fifo_wr;
    logic [63:0] fifo_data;
    logic        fifo_full;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] bin_count;

    modport slave (
        input  cmd_start, cmd_stop, cfg_tau, cfg_nbins, cnt_rdy, cnt_data, fifo_full,
        output cnt_reset, cnt_write, cnt_tau, fifo_wr, fifo_data, busy, done,
               overflow, drop_count, bin_count
    );

    modport master (
        output cmd_start, cmd_stop, cfg_tau, cfg_nbins, cnt_rdy, cnt_data, fifo_full,
        input  cnt_reset, cnt_write, cnt_tau, fifo_wr, fifo_data, busy, done,
               overflow, drop_count, bin_count
    );
endinterface

// File: rtl/pls_acq_ctrl.sv
// Acquisition sequencer: clears/configures the photon bin counter, runs it for
// N bins or until stopped, and forwards bin words to the FIFO with drop accounting.
module pls_acq_ctrl #(
    parameter int CLR_CYCLES = 2,
    parameter int DISCARD    = 1,
    parameter int MIN_TAU    = 2
) (
    input  logic          CLK,
    input  logic          RESET_N,
    pls_acq_ctrl_if.slave bus
);
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
    localparam int DW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
    localparam logic [CW-1:0] CLR_INIT = CW'(CLR_CYCLES - 1);
    localparam logic [DW-1:0] DISC_LIM = DW'(DISCARD);
    localparam logic [31:0]   TAU_MIN  = 32'(MIN_TAU);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_FINISH} state_e;

    state_e        state_q;
    logic [CW-1:0] clr_q;
    logic [DW-1:0] disc_q;
    logic [31:0]   nbins_q, tau_q, bin_q;
    logic [15:0]   drop_q;
    logic [63:0]   fifo_data_q;
    logic          cnt_reset_q, cnt_write_q, fifo_wr_q, busy_q, done_q, ovf_q;

    logic [31:0] tau_d, bin_d;
    logic [15:0] drop_d;
    logic        discarding, push, last_bin;

    assign tau_d      = (bus.cfg_tau < TAU_MIN) ? TAU_MIN : bus.cfg_tau;
    assign bin_d      = bin_q + 32'd1;
    assign drop_d     = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
    assign discarding = (disc_q < DISC_LIM);
    assign push       = bus.cnt_rdy && !discarding && !bus.fifo_full;
    // nbins of zero means free-running, so bin_q is allowed to wrap
    assign last_bin   = push && (nbins_q != 32'd0) && (bin_d == nbins_q);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            clr_q       <= '0;
            disc_q      <= '0;
            nbins_q     <= '0;
            tau_q       <= '0;
            bin_q       <= '0;
            drop_q      <= '0;
            fifo_data_q <= '0;
            cnt_reset_q <= 1'b1;
            cnt_write_q <= 1'b0;
            fifo_wr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            fifo_wr_q   <= 1'b0;
            cnt_write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_reset_q <= 1'b1;
                    if (bus.cmd_start) begin
                        tau_q   <= tau_d;
                        nbins_q <= bus.cfg_nbins;
                        bin_q   <= '0;
                        drop_q  <= '0;
                        ovf_q   <= 1'b0;
                        disc_q  <= '0;
                        clr_q   <= CLR_INIT;
                        busy_q  <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (bus.cmd_stop) begin
                        state_q <= S_FINISH;
                    end else if (clr_q == '0) begin
                        cnt_reset_q <= 1'b0;
                        cnt_write_q <= 1'b1;
                        state_q     <= S_LOAD;
                    end else begin
                        clr_q <= clr_q - 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.cmd_stop) begin
                        cnt_reset_q <= 1'b1;
                        state_q     <= S_FINISH;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.cnt_rdy) begin
                        if (discarding) begin
                            disc_q <= disc_q + 1'b1;
                        end else if (!bus.fifo_full) begin
                            fifo_wr_q   <= 1'b1;
                            fifo_data_q <= bus.cnt_data;
                            bin_q       <= bin_d;
                        end else begin
                            ovf_q  <= 1'b1;
                            drop_q <= drop_d;
                        end
                    end
                    // a word coinciding with stop is still handled above
                    if (bus.cmd_stop || last_bin) begin
                        cnt_reset_q <= 1'b1;
                        state_q     <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    cnt_reset_q <= 1'b1;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cnt_reset  = cnt_reset_q;
    assign bus.cnt_write  = cnt_write_q;
    assign bus.cnt_tau    = tau_q;
    assign bus.fifo_wr    = fifo_wr_q;
    assign bus.fifo_data  = fifo_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.drop_count = drop_q;
    assign bus.bin_count  = bin_q;
endmodule

// File: tb/tb_pls_acq_ctrl.sv
// Directed bench for pls_acq_ctrl: each task drives one scenario and checks inline.
module tb_pls_acq_ctrl;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   tests = 0;
    int   fails = 0;

    int          n_push = 0, n_done = 0, n_write = 0;
    logic [63:0] pushed [$];

    pls_acq_ctrl_if bus ();
    pls_acq_ctrl #(.CLR_CYCLES(2), .DISCARD(1), .MIN_TAU(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.fifo_wr === 1'b1) begin n_push++; pushed.push_back(bus.fifo_data); end
        if (bus.done === 1'b1) n_done++;
        if (bus.cnt_write === 1'b1) n_write++;
    end

    function automatic logic [63:0] word(int i);
        return {1'b1, 31'(i + 100), 32'(i * 1000)};
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic clr_mon();
        n_push = 0; n_done = 0; n_write = 0; pushed.delete();
    endtask

    // returns at the negedge of the first CLEAR cycle
    task automatic do_start(input logic [31:0] tau, input logic [31:0] nb);
        bus.cfg_tau = tau; bus.cfg_nbins = nb; bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.busy === 1'b0) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic send(input logic [63:0] d, input logic full);
        bus.cnt_rdy = 1'b1; bus.cnt_data = d; bus.fifo_full = full;
        tick();
        bus.cnt_rdy = 1'b0; bus.fifo_full = 1'b0;
    endtask

    task automatic stop_run();
        bit ok;
        bus.cmd_stop = 1'b1; tick(); bus.cmd_stop = 1'b0;
        wait_idle(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stop_run_timeout: busy=%b want 0", bus.busy); end
        tick(); tick();
    endtask

    task automatic test_reset();
        bus.cmd_start = 0; bus.cmd_stop = 0; bus.cfg_tau = 0; bus.cfg_nbins = 0;
        bus.cnt_rdy = 0; bus.cnt_data = 0; bus.fifo_full = 0;
        RESET_N = 1'b0;
        #12;
        tests++; if (bus.cnt_reset !== 1'b1) begin fails++; $display("FAIL rst_cnt_reset: got %b want 1", bus.cnt_reset); end
        tests++; if (bus.cnt_write !== 1'b0) begin fails++; $display("FAIL rst_cnt_write: got %b want 0", bus.cnt_write); end
        tests++; if (bus.cnt_tau !== 32'd0) begin fails++; $display("FAIL rst_cnt_tau: got %0d want 0", bus.cnt_tau); end
        tests++; if (bus.fifo_wr !== 1'b0 || bus.fifo_data !== 64'd0) begin fails++; $display("FAIL rst_fifo: wr=%b data=%h want 0/0", bus.fifo_wr, bus.fifo_data); end
        tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL rst_busy_done: %b/%b want 0/0", bus.busy, bus.done); end
        tests++; if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd0 || bus.bin_count !== 32'd0) begin
            fails++; $display("FAIL rst_counts: ovf=%b drop=%0d bin=%0d want 0/0/0", bus.overflow, bus.drop_count, bus.bin_count); end
        tick(); RESET_N = 1'b1; tick(); tick();
        tests++; if (bus.busy !== 1'b0 || bus.cnt_reset !== 1'b1) begin fails++; $display("FAIL rst_idle: busy=%b cnt_reset=%b want 0/1", bus.busy, bus.cnt_reset); end
    endtask

    task automatic test_basic();
        bit ok;
        clr_mon();
        do_start(32'd1000, 32'd4);
        tests++; if (bus.busy !== 1'b1 || bus.cnt_reset !== 1'b1) begin fails++; $display("FAIL basic_clear1: busy=%b cnt_reset=%b want 1/1", bus.busy, bus.cnt_reset); end
        tick();
        tests++; if (bus.cnt_reset !== 1'b1 || bus.cnt_write !== 1'b0) begin fails++; $display("FAIL basic_clear2: cnt_reset=%b cnt_write=%b want 1/0", bus.cnt_reset, bus.cnt_write); end
        tick();
        tests++; if (bus.cnt_reset !== 1'b0 || bus.cnt_write !== 1'b1 || bus.cnt_tau !== 32'd1000) begin
            fails++; $display("FAIL basic_load: cnt_reset=%b cnt_write=%b tau=%0d want 0/1/1000", bus.cnt_reset, bus.cnt_write, bus.cnt_tau); end
        tick();
        tests++; if (bus.cnt_write !== 1'b0 || bus.cnt_reset !== 1'b0) begin fails++; $display("FAIL basic_run: cnt_write=%b cnt_reset=%b want 0/0", bus.cnt_write, bus.cnt_reset); end
        for (int w = 0; w < 5; w++) begin
            repeat (999) tick();
            send(word(w), 1'b0);
            if (w == 0) begin
                tests++; if (bus.fifo_wr !== 1'b0 || bus.bin_count !== 32'd0) begin fails++; $display("FAIL basic_discard: wr=%b bin=%0d want 0/0", bus.fifo_wr, bus.bin_count); end
            end
        end
        tests++; if (bus.busy !== 1'b1 || bus.cnt_reset !== 1'b1 || bus.fifo_wr !== 1'b1) begin
            fails++; $display("FAIL basic_finish: busy=%b cnt_reset=%b wr=%b want 1/1/1", bus.busy, bus.cnt_reset, bus.fifo_wr); end
        tick();
        tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL basic_done: done=%b busy=%b want 1/0", bus.done, bus.busy); end
        wait_idle(ok); tick(); tick();
        tests++; if (n_push !== 4 || bus.bin_count !== 32'd4) begin fails++; $display("FAIL basic_pushes: pushes=%0d bin=%0d want 4/4", n_push, bus.bin_count); end
        tests++; if (n_write !== 1 || n_done !== 1) begin fails++; $display("FAIL basic_pulses: writes=%0d dones=%0d want 1/1", n_write, n_done); end
        tests++; if (pushed.size() != 4 || pushed[0] !== word(1) || pushed[3] !== word(4)) begin
            fails++; $display("FAIL basic_data: n=%0d first=%h want %h", pushed.size(), (pushed.size() > 0) ? pushed[0] : 64'd0, word(1)); end
        tests++; if (bus.cnt_reset !== 1'b1) begin fails++; $display("FAIL basic_idle_reset: got %b want 1", bus.cnt_reset); end
    endtask

    task automatic test_tau_floor();
        do_start(32'd0, 32'd0); tick(); tick();
        tests++; if (bus.cnt_tau !== 32'd2 || bus.cnt_write !== 1'b1) begin fails++; $display("FAIL tau_floor0: tau=%0d write=%b want 2/1", bus.cnt_tau, bus.cnt_write); end
        tick(); stop_run();
        do_start(32'd1, 32'd0); tick(); tick();
        tests++; if (bus.cnt_tau !== 32'd2) begin fails++; $display("FAIL tau_floor1: tau=%0d want 2", bus.cnt_tau); end
        tick(); stop_run();
        do_start(32'd3, 32'd0); tick(); tick();
        tests++; if (bus.cnt_tau !== 32'd3) begin fails++; $display("FAIL tau_above: tau=%0d want 3", bus.cnt_tau); end
        tick(); stop_run();
    endtask

    task automatic test_back_to_back();
        clr_mon();
        do_start(32'd5, 32'd0); tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            bus.cnt_rdy = 1'b1; bus.cnt_data = word(i + 20);
            tick();
            if (i == 0) begin
                tests++; if (bus.fifo_wr !== 1'b0) begin fails++; $display("FAIL b2b_discard: wr=%b want 0", bus.fifo_wr); end
            end else begin
                tests++; if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== word(i + 20)) begin
                    fails++; $display("FAIL b2b_word%0d: wr=%b data=%h want 1/%h", i, bus.fifo_wr, bus.fifo_data, word(i + 20)); end
            end
        end
        bus.cnt_rdy = 1'b0; tick();
        tests++; if (bus.fifo_wr !== 1'b0 || bus.bin_count !== 32'd9 || n_push !== 9) begin
            fails++; $display("FAIL b2b_total: wr=%b bin=%0d pushes=%0d want 0/9/9", bus.fifo_wr, bus.bin_count, n_push); end
        stop_run();
    endtask

    task automatic test_overflow();
        bit ok;
        bit full_pat [0:10] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        clr_mon();
        do_start(32'd5, 32'd5); tick(); tick(); tick();
        for (int i = 0; i <= 10; i++) begin
            send(word(i + 40), full_pat[i]);
            tick();
        end
        wait_idle(ok); tick(); tick();
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL ovf_timeout: busy=%b want 0", bus.busy); end
        tests++; if (n_push !== 5 || bus.bin_count !== 32'd5) begin fails++; $display("FAIL ovf_pushes: pushes=%0d bin=%0d want 5/5", n_push, bus.bin_count); end
        tests++; if (bus.overflow !== 1'b1 || bus.drop_count !== 16'd3) begin fails++; $display("FAIL ovf_drops: ovf=%b drop=%0d want 1/3", bus.overflow, bus.drop_count); end
        tests++; if (n_done !== 1 || pushed.size() != 5 || pushed[4] !== word(48)) begin
            fails++; $display("FAIL ovf_last: dones=%0d n=%0d last=%h want 1/5/%h", n_done, pushed.size(), (pushed.size() == 5) ? pushed[4] : 64'd0, word(48)); end
    endtask

    task automatic test_stop();
        clr_mon();
        do_start(32'd9, 32'd0);
        tests++; if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd0 || bus.bin_count !== 32'd0) begin
            fails++; $display("FAIL stop_start_clears: ovf=%b drop=%0d bin=%0d want 0/0/0", bus.overflow, bus.drop_count, bus.bin_count); end
        bus.cmd_stop = 1'b1; tick(); bus.cmd_stop = 1'b0;
        tests++; if (bus.busy !== 1'b1 || bus.cnt_reset !== 1'b1 || bus.cnt_write !== 1'b0) begin
            fails++; $display("FAIL stop_clear_finish: busy=%b rst=%b wr=%b want 1/1/0", bus.busy, bus.cnt_reset, bus.cnt_write); end
        tick();
        tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL stop_clear_done: done=%b busy=%b want 1/0", bus.done, bus.busy); end
        tick();
        tests++; if (n_write !== 0 || n_done !== 1) begin fails++; $display("FAIL stop_clear_pulses: writes=%0d dones=%0d want 0/1", n_write, n_done); end

        // stop together with a data word in RUN
        do_start(32'd9, 32'd0); tick(); tick(); tick();
        send(word(60), 1'b0);
        bus.cmd_stop = 1'b1; send(word(61), 1'b0); bus.cmd_stop = 1'b0;
        tests++; if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== word(61) || bus.bin_count !== 32'd1) begin
            fails++; $display("FAIL stop_rdy_push: wr=%b data=%h bin=%0d want 1/%h/1", bus.fifo_wr, bus.fifo_data, bus.bin_count, word(61)); end
        tick();
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL stop_rdy_done: done=%b want 1", bus.done); end
        tick();

        // start while busy is ignored
        do_start(32'd10, 32'd0); tick(); tick(); tick();
        send(word(70), 1'b0); send(word(71), 1'b0); send(word(72), 1'b0);
        bus.cfg_tau = 32'd77; bus.cfg_nbins = 32'd1; bus.cmd_start = 1'b1; tick(); bus.cmd_start = 1'b0;
        tick(); tick();
        tests++; if (bus.bin_count !== 32'd2 || bus.busy !== 1'b1 || bus.cnt_reset !== 1'b0 || bus.cnt_tau !== 32'd10) begin
            fails++; $display("FAIL start_busy: bin=%0d busy=%b rst=%b tau=%0d want 2/1/0/10", bus.bin_count, bus.busy, bus.cnt_reset, bus.cnt_tau); end
        stop_run();

        // start and stop together in IDLE: start wins, run proceeds to LOAD
        clr_mon();
        bus.cfg_tau = 32'd20; bus.cfg_nbins = 32'd0; bus.cmd_start = 1'b1; bus.cmd_stop = 1'b1;
        tick(); bus.cmd_start = 1'b0; bus.cmd_stop = 1'b0;
        tick(); tick();
        tests++; if (bus.busy !== 1'b1 || bus.cnt_write !== 1'b1) begin fails++; $display("FAIL start_stop_idle: busy=%b wr=%b want 1/1", bus.busy, bus.cnt_write); end
        tick(); stop_run();
    endtask

    task automatic test_async_reset();
        bit ok;
        clr_mon();
        do_start(32'd30, 32'd0); tick(); tick(); tick();
        send(word(80), 1'b0); send(word(81), 1'b0);
        #2 RESET_N = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.cnt_reset !== 1'b1 || bus.cnt_tau !== 32'd0 || bus.bin_count !== 32'd0) begin
            fails++; $display("FAIL arst_state: busy=%b rst=%b tau=%0d bin=%0d want 0/1/0/0", bus.busy, bus.cnt_reset, bus.cnt_tau, bus.bin_count); end
        tests++; if (bus.fifo_wr !== 1'b0 || bus.fifo_data !== 64'd0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL arst_outs: wr=%b data=%h done=%b want 0/0/0", bus.fifo_wr, bus.fifo_data, bus.done); end
        tick(); tick(); RESET_N = 1'b1; tick(); tick();
        tests++; if (n_done !== 0 || bus.busy !== 1'b0) begin fails++; $display("FAIL arst_no_done: dones=%0d busy=%b want 0/0", n_done, bus.busy); end
        clr_mon();
        do_start(32'd50, 32'd1); tick(); tick(); tick();
        send(word(90), 1'b0); send(word(91), 1'b0);
        wait_idle(ok); tick(); tick();
        tests++; if (ok !== 1'b1 || n_push !== 1 || n_done !== 1 || bus.bin_count !== 32'd1) begin
            fails++; $display("FAIL arst_restart: idle=%b pushes=%0d dones=%0d bin=%0d want 1/1/1/1", ok, n_push, n_done, bus.bin_count); end
        tests++; if (n_write !== 1 || bus.cnt_tau !== 32'd50) begin fails++; $display("FAIL arst_restart_load: writes=%0d tau=%0d want 1/50", n_write, bus.cnt_tau); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tau_floor();
        test_back_to_back();
        test_overflow();
        test_stop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pls_acq_ctrl.md
# pls_acq_ctrl

Acquisition sequencer for the photon-count bin counter. It clears and configures the counter, then runs it for a programmed number of bins or until stopped. Each bin word the counter produces is forwarded to the downstream 64-bit FIFO, with drop accounting when the FIFO is full. It sits between the host register interface and the counter/FIFO pair.

## Interface
Parameters:
- CLR_CYCLES, 2: cycles that cnt_reset is held in CLEAR (minimum 1).
- DISCARD, 1: number of leading bin words dropped after each start; these carry stale photon history.
- MIN_TAU, 2: floor applied to cfg_tau.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle start pulse; honoured only in IDLE.
- cmd_stop  in  1  one-cycle stop pulse; honoured in CLEAR, LOAD and RUN.
- cfg_tau  in  32  clocks per bin; sampled on the accepted cmd_start.
- cfg_nbins  in  32  bins to store; 0 means run until cmd_stop. Sampled on the accepted cmd_start.
- cnt_reset  out  1  drives the counter's active-high RESET.
- cnt_write  out  1  one-cycle load strobe for the counter's Tao register.
- cnt_tau  out  32  value presented to the counter's Tao_Q.
- cnt_rdy  in  1  counter data-valid; level-sensitive, one word per high cycle.
- cnt_data  in  64  counter word: [63] trigger marker, [62:32] photon count, [31:0] clock count.
- fifo_wr  out  1  FIFO push strobe.
- fifo_data  out  64  pushed word.
- fifo_full  in  1  FIFO full.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on entry to IDLE from FINISH.
- overflow  out  1  sticky; set on the first dropped word.
- drop_count  out  16  words dropped because of fifo_full; saturates at 0xFFFF.
- bin_count  out  32  words pushed since the last accepted start.

## Operation
States and transitions:
- IDLE: cnt_reset=1. An accepted cmd_start latches cfg_tau into cnt_tau as max(cfg_tau, MIN_TAU) and latches cfg_nbins. It also clears bin_count, drop_count, overflow and the discard counter, then moves to CLEAR.
- CLEAR: cnt_reset=1 for CLR_CYCLES cycles, then LOAD.
- LOAD: cnt_reset=0 and cnt_write=1 for exactly one cycle, then RUN.
- RUN: cnt_reset=0. On each cycle with cnt_rdy=1:
  - While the discard counter is below DISCARD, the counter increments and the word is dropped. This does not count as a FIFO drop.
  - Otherwise, if fifo_full=0, the word is pushed unchanged and bin_count increments.
  - Otherwise, overflow is set and drop_count increments (saturating). Dropped words do not advance bin_count.
- RUN exits to FINISH when cfg_nbins≠0 and a push brings bin_count to cfg_nbins, or when cmd_stop is seen.
- FINISH: cnt_reset=1 for one cycle, then IDLE with done=1 in the cycle IDLE is entered.
- cmd_stop in CLEAR or LOAD goes directly to FINISH. No cnt_write is issued if LOAD has not yet occurred.

Rules and boundary conditions:
- cmd_start outside IDLE is ignored.
- If cmd_start and cmd_stop arrive together in IDLE, the start is accepted; the stop is ignored because it is not in a stop-honouring state.
- If cmd_stop and cnt_rdy coincide in RUN, the word is still processed (pushed or dropped), then the block goes to FINISH.
- cnt_rdy outside RUN is ignored.
- bin_count is 32-bit and wraps only when cfg_nbins=0. drop_count does not wrap.
- Asserting RESET_N=0 mid-run aborts immediately to IDLE with reset values; no done pulse is generated.

## Timing
- Reset values: cnt_reset=1, cnt_write=0, cnt_tau=0, fifo_wr=0, fifo_data=0, busy=0, done=0, overflow=0, drop_count=0, bin_count=0; state IDLE.
- All outputs are registered.
- Start latency: cmd_start accepted at cycle t gives CLEAR in t+1..t+CLR_CYCLES, cnt_write high at t+CLR_CYCLES+1, and RUN from t+CLR_CYCLES+2.
- Data latency: cnt_rdy at cycle n gives fifo_wr and fifo_data at n+1. fifo_full is sampled at cycle n.
- Throughput: one word per cycle sustained, which covers the case where the counter emits on consecutive cycles.
- bin_count and drop_count update in the same cycle as fifo_wr, or in the cycle a drop would have pushed.
- Terminal bin at cycle n: fifo_wr at n+1, FINISH at n+1, done at n+2.

## Test plan
- Basic run: cfg_tau=1000, cfg_nbins=4, CLR_CYCLES=2, one counter word every 1000 clocks. Require: cnt_reset low 3 cycles after start; exactly one cnt_write with cnt_tau=1000; the first word discarded; 4 pushes; bin_count=4; done pulses once; the block returns to IDLE with cnt_reset=1.
- Tau floor: cfg_tau=0 and then cfg_tau=1. Require cnt_tau=2 in both cases.
- Back-to-back data: cnt_rdy held high for 10 cycles with cfg_nbins=0 and DISCARD=1. Require 9 consecutive fifo_wr cycles, each carrying the cnt_data from one cycle earlier.
- FIFO overflow: fifo_full=1 during 3 of 8 words, cfg_nbins=5. Require 5 pushes, overflow=1, drop_count=3, and the run ending after the 5th push rather than the 8th word.
- Stop handling:
  - cmd_stop during CLEAR: no cnt_write, FINISH, done pulse.
  - cmd_stop coinciding with cnt_rdy in RUN: that word is pushed, then done.
  - cmd_start while busy: ignored, bin_count unaffected.
- Async reset mid-RUN: RESET_N pulled low asynchronously. Require immediate IDLE, all outputs at reset values, no done pulse, and a subsequent cmd_start working normally.
